// File: rtl/pipe_addsub_n.sv
// Pipelined N-bit adder/subtractor, one CHUNK-bit slice per stage.
// Ports: clk, rst_n, in_valid/in_ready/a/b/cin/sub, out_valid/out_ready/sum/cout/ovf.
module pipe_addsub_n #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  localparam int STAGES = WIDTH / CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  bx_q  [STAGES];
  logic [WIDTH-1:0]  bx_d  [STAGES];

  logic             advance;
  logic [WIDTH-1:0] bx_in;
  logic             ci_in;
  logic [CHUNK:0]   sl;

  function automatic logic [CHUNK:0] add_sl(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             c
  );
    add_sl = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  always_comb begin
    advance = out_ready | ~vld_q[STAGES-1];
    bx_in   = sub ? ~b : b;
    // subtract is a + ~b + 1, so cin is forced high
    ci_in   = sub | cin;
    sl      = '0;
    vld_d   = vld_q;
    c_d     = c_q;
    for (int k = 0; k < STAGES; k++) begin
      res_d[k] = res_q[k];
      a_d[k]   = a_q[k];
      bx_d[k]  = bx_q[k];
    end
    if (advance) begin
      sl = add_sl(a[CHUNK-1:0], bx_in[CHUNK-1:0], ci_in);
      vld_d[0] = in_valid;
      c_d[0]   = sl[CHUNK];
      res_d[0] = '0;
      res_d[0][CHUNK-1:0] = sl[CHUNK-1:0];
      a_d[0]   = a;
      bx_d[0]  = bx_in;
      for (int k = 1; k < STAGES; k++) begin
        sl = add_sl(a_q[k-1][k*CHUNK +: CHUNK],
                    bx_q[k-1][k*CHUNK +: CHUNK],
                    c_q[k-1]);
        vld_d[k] = vld_q[k-1];
        c_d[k]   = sl[CHUNK];
        // lower slices ride along, slice k is filled here
        res_d[k] = res_q[k-1];
        res_d[k][k*CHUNK +: CHUNK] = sl[CHUNK-1:0];
        a_d[k]   = a_q[k-1];
        bx_d[k]  = bx_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
      end
    end else begin
      vld_q <= vld_d;
      c_q   <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= res_d[k];
        a_q[k]   <= a_d[k];
        bx_q[k]  <= bx_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf = (a_q[STAGES-1][WIDTH-1] == bx_q[STAGES-1][WIDTH-1])
             & (sum[WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipe_addsub_n.sv
// Directed bench for pipe_addsub_n: 32/8 (latency 4) and 8/8 (latency 1).
// Ports of both instances driven from one linear initial block.
module tb_pipe_addsub_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub;
  logic [31:0] a, b, sum;
  logic        out_valid, out_ready, cout, ovf;

  logic        in_valid8, in_ready8, cin8, sub8;
  logic [7:0]  a8, b8, sum8;
  logic        out_valid8, out_ready8, cout8, ovf8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_addsub_n #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipe_addsub_n #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb,
                      input logic xc, input logic xs);
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] es,
                         input logic ec, input logic eo);
    chk({tag, ".vld"},  {31'd0, out_valid}, 32'd1);
    chk({tag, ".sum"},  sum, es);
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, ".ovf"},  {31'd0, ovf}, {31'd0, eo});
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    out_ready8 = 1'b1;
    #12;
    chk("rst.vld", {31'd0, out_valid}, 32'd0);
    chk("rst.sum", sum, 32'd0);
    chk("rst.rdy", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick(2);

    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    chk("ripple.lat1", {31'd0, out_valid}, 32'd0);
    tick(2);
    chk("ripple.lat3", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk_out("ripple", 32'h0, 1'b1, 1'b0);
    tick(1);
    chk("ripple.gone", {31'd0, out_valid}, 32'd0);

    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    tick(3);
    chk_out("ovf", 32'h8000_0000, 1'b0, 1'b1);

    send(32'h5, 32'h7, 1'b1, 1'b1);
    send(32'h7, 32'h5, 1'b0, 1'b1);
    tick(2);
    chk_out("sub57", 32'hFFFF_FFFE, 1'b0, 1'b0);
    tick(1);
    chk_out("sub75", 32'h2, 1'b1, 1'b0);
    tick(1);

    in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a = i; b = i;
      tick(1);
    end
    a = 5; b = 5;
    out_ready = 1'b0;
    #1;
    chk("bp.vld", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp.rdy", {31'd0, in_ready}, 32'd0);
      chk("bp.hold", sum, 32'h2);
      tick(1);
    end
    chk("bp.hold.end", sum, 32'h2);
    out_ready = 1'b1;
    #1;
    chk("bp.rdy.rel", {31'd0, in_ready}, 32'd1);
    tick(1);
    in_valid = 1'b0;
    chk_out("bp.r2", 32'h4, 1'b0, 1'b0);
    tick(1);
    chk_out("bp.r3", 32'h6, 1'b0, 1'b0);
    tick(1);
    chk_out("bp.r4", 32'h8, 1'b0, 1'b0);
    tick(1);
    chk_out("bp.r5", 32'hA, 1'b0, 1'b0);
    tick(1);
    chk("bp.drain", {31'd0, out_valid}, 32'd0);

    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + i; b = 32'h1;
      tick(1);
    end
    in_valid = 1'b0;
    tick(1);
    chk("rst.pre", {31'd0, out_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst.mid.vld", {31'd0, out_valid}, 32'd0);
    chk("rst.mid.sum", sum, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rst.stale", {31'd0, out_valid}, 32'd0);
    end
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    tick(2);
    chk("rst.new.early", {31'd0, out_valid}, 32'd0);
    tick(1);
    chk_out("rst.new", 32'h2345_6789, 1'b0, 1'b0);
    tick(1);

    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
    #1;
    chk("d8.pre", {31'd0, out_valid8}, 32'd0);
    tick(1);
    in_valid8 = 1'b0;
    chk("d8.vld", {31'd0, out_valid8}, 32'd1);
    chk("d8.sum", {24'd0, sum8}, 32'hFF);
    chk("d8.cout", {31'd0, cout8}, 32'd1);
    chk("d8.ovf", {31'd0, ovf8}, 32'd0);
    a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1; in_valid8 = 1'b1;
    tick(1);
    in_valid8 = 1'b0;
    chk("d8s.sum", {24'd0, sum8}, 32'h7F);
    chk("d8s.cout", {31'd0, cout8}, 32'd1);
    chk("d8s.ovf", {31'd0, ovf8}, 32'd1);
    tick(1);
    chk("d8.gone", {31'd0, out_valid8}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
